// File: rtl/clz_denorm_pkg.sv
// Shared definitions for the clz de-normalise shifter: FSM state encoding
// and a constant-evaluable ceil(log2) helper for derived widths.
package clz_denorm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int unsigned value);
        int          r;
        int unsigned x;
        r = 0;
        x = value - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clz_shr_step.sv
// One log-step stage of the de-normalise shifter: a logical right shift by
// 2**k when enabled, pass-through otherwise.
module clz_shr_step
    import clz_denorm_pkg::*;
#(
    parameter int BITS_IN  = 16,
    parameter int BITS_OUT = clog2(BITS_IN)
) (
    input  logic [BITS_IN-1:0]  acc,
    input  logic [BITS_OUT-1:0] k,
    input  logic                en,
    output logic [BITS_IN-1:0]  res
);

    always_comb begin
        res = acc;
        if (en) begin
            res = acc >> (32'd1 << k);
        end
    end

endmodule

// File: rtl/clz_denorm.sv
// Restores a fixed-point value from a normalised mantissa and its leading-zero
// count by right-shifting one binary stage per clock, with valid/ready on both sides.
module clz_denorm
    import clz_denorm_pkg::*;
#(
    parameter int BITS_IN  = 16,
    parameter int BITS_OUT = clog2(BITS_IN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BITS_IN-1:0]  mant,
    input  logic [BITS_OUT-1:0] lzc,
    input  logic                nz,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [BITS_IN-1:0]  out,
    output logic                err
);

    localparam logic [BITS_OUT-1:0] LAST_STAGE = BITS_OUT'(BITS_OUT - 1);

    state_t              state_q, state_d;
    logic [BITS_OUT-1:0] cnt_q, cnt_d;
    logic [BITS_IN-1:0]  acc_q, acc_d;
    logic [BITS_OUT-1:0] lzc_q, lzc_d;
    logic                err_q, err_d;
    logic [BITS_IN-1:0]  shr_res;

    clz_shr_step #(
        .BITS_IN  (BITS_IN),
        .BITS_OUT (BITS_OUT)
    ) u_shr_step (
        .acc (acc_q),
        .k   (cnt_q),
        .en  (lzc_q[cnt_q]),
        .res (shr_res)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lzc_d   = lzc_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    acc_d   = mant;
                    lzc_d   = lzc;
                    err_d   = nz & ~mant[BITS_IN-1];
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                    // Zero result: run only the final (no-op) stage so the
                    // result appears one edge after accept.
                    if (!nz) begin
                        acc_d = '0;
                        lzc_d = '0;
                        cnt_d = LAST_STAGE;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = shr_res;
                if (cnt_q == LAST_STAGE) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + BITS_OUT'(1);
                end
            end
            ST_DONE: begin
                if (m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lzc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lzc_q   <= lzc_d;
            err_q   <= err_d;
        end
    end

    assign s_ready = (state_q == ST_IDLE) & ~rst;
    assign m_valid = (state_q == ST_DONE);
    assign out     = acc_q;
    assign err     = err_q;

endmodule

// File: tb/tb_clz_denorm.sv
// Directed and round-trip checks for clz_denorm at BITS_IN = 16.
module tb_clz_denorm;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] mant;
    logic [3:0]  lzc;
    logic        nz;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] out_w;
    logic        err;

    int n_vec;
    int n_miscmp;

    clz_denorm #(
        .BITS_IN (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .mant    (mant),
        .lzc     (lzc),
        .nz      (nz),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .out     (out_w),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clz16(input logic [15:0] x);
        int n;
        n = 0;
        for (int i = 15; i >= 0; i--) begin
            if (x[i]) break;
            n++;
        end
        return n;
    endfunction

    // elat < 0 skips the exact latency check.
    task automatic xact(input logic [15:0] m, input logic [3:0] l, input logic z,
                        input logic [15:0] eo, input logic ee, input int elat, input int stall);
        int          n;
        logic [15:0] held_out;
        logic        held_err;
        n = 0;
        while (!s_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("s_ready_before_accept", {31'd0, s_ready}, 32'd1);
        mant    = m;
        lzc     = l;
        nz      = z;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        mant    = 16'($urandom);
        lzc     = 4'($urandom);
        nz      = 1'($urandom);
        check("s_ready_after_accept", {31'd0, s_ready}, 32'd0);
        n = 0;
        while (!m_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (elat >= 0) check("latency", n, elat);
        else           check("m_valid_seen", {31'd0, m_valid}, 32'd1);
        check("out", {16'd0, out_w}, {16'd0, eo});
        check("err", {31'd0, err}, {31'd0, ee});
        held_out = out_w;
        held_err = err;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_m_valid", {31'd0, m_valid}, 32'd1);
            check("stall_out", {16'd0, out_w}, {16'd0, held_out});
            check("stall_err", {31'd0, err}, {31'd0, held_err});
            check("stall_s_ready", {31'd0, s_ready}, 32'd0);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("m_valid_drop", {31'd0, m_valid}, 32'd0);
        check("s_ready_after_hs", {31'd0, s_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] x;
        int          c;
        n_vec    = 0;
        n_miscmp = 0;
        rst      = 1'b1;
        s_valid  = 1'b0;
        m_ready  = 1'b0;
        mant     = '0;
        lzc      = '0;
        nz       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_out", {16'd0, out_w}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

        xact(16'h8000, 4'd15, 1'b1, 16'h0001, 1'b0, 4, 0);
        xact(16'hF000, 4'd0,  1'b1, 16'hF000, 1'b0, 4, 0);
        xact(16'hFFFF, 4'd7,  1'b0, 16'h0000, 1'b0, 1, 0);
        xact(16'h4000, 4'd2,  1'b1, 16'h1000, 1'b1, 4, 5);
        xact(16'hA5A5, 4'd5,  1'b1, 16'h052D, 1'b0, 4, 1);

        // Reset in the middle of SHIFT
        @(posedge clk); #1;
        mant    = 16'hFFFF;
        lzc     = 4'd1;
        nz      = 1'b1;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        check("midrst_s_ready", {31'd0, s_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst_no_output", {31'd0, m_valid}, 32'd0);
        end
        xact(16'hC000, 4'd3, 1'b1, 16'h1800, 1'b0, 4, 0);

        for (int t = 0; t < 1000; t++) begin
            x = 16'($urandom_range(1, 65535));
            c = clz16(x);
            xact(x << c, 4'(c), 1'b1, x, 1'b0, 4, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
